aes_key_expand: RTL and testbench



---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_expand.sv | 104 ++++++++++
 tb/tb_aes_key_expand.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: sbox and rcon tables, key-length encoding, key-schedule FSM states.
package aes_pkg;

  localparam logic       AES_128_BIT_KEY = 1'b0;
  localparam logic       AES_256_BIT_KEY = 1'b1;
  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;

  typedef enum logic {ST_IDLE, ST_GEN} ks_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Indices past the table return 0 so stray counter values are harmless.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return (i < 4'd10) ? RCON[i] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel sbox lookups on a 32-bit word, one per byte lane.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128/256 key schedule: one round key per clock into a bank, then combinational
// lookup by round index for the encipher core.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_KEYS = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         keylen,
  input  logic [255:0] key,
  input  logic [3:0]   round_idx,
  output logic [127:0] round_key,
  output logic         ready
);

  ks_state_e    state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         keylen_q, keylen_d;
  logic         ready_q, ready_d;
  logic [127:0] bank_q [NUM_KEYS];

  logic [3:0]   last_idx, prev_idx, prev2_idx, rc_idx;
  logic [127:0] p, q, base;
  logic [31:0]  sub_in, sub_out, t;
  logic         odd256;
  logic [127:0] next_key;

  assign last_idx  = keylen_q ? AES256_ROUNDS : AES128_ROUNDS;
  assign prev_idx  = cnt_q - 4'd1;
  assign prev2_idx = cnt_q - 4'd2;
  assign p         = (int'(prev_idx)  < NUM_KEYS) ? bank_q[prev_idx]  : '0;
  assign q         = (int'(prev2_idx) < NUM_KEYS) ? bank_q[prev2_idx] : '0;

  // AES-256 odd steps skip RotWord and rcon; the rest of the datapath is shared.
  assign odd256 = keylen_q && cnt_q[0];
  assign sub_in = odd256 ? p[31:0] : {p[23:0], p[31:24]};
  assign rc_idx = keylen_q ? ({1'b0, cnt_q[3:1]} - 4'd1) : prev_idx;

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  assign t    = odd256 ? sub_out : (sub_out ^ {rcon(rc_idx), 24'h0});
  assign base = keylen_q ? q : p;

  always_comb begin
    next_key[127:96] = base[127:96] ^ t;
    next_key[95:64]  = base[95:64]  ^ next_key[127:96];
    next_key[63:32]  = base[63:32]  ^ next_key[95:64];
    next_key[31:0]   = base[31:0]   ^ next_key[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    keylen_d = keylen_q;
    ready_d  = ready_q;
    if (init) begin
      ready_d  = 1'b0;
      keylen_d = keylen;
      cnt_d    = (keylen == AES_256_BIT_KEY) ? 4'd2 : 4'd1;
      state_d  = ST_GEN;
    end else if (state_q == ST_GEN) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == last_idx) begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      keylen_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      keylen_q <= keylen_d;
      ready_q  <= ready_d;
    end
  end

  // Restart leaves stale entries in place; reads past the last index are masked below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) bank_q[i] <= '0;
    end else if (init) begin
      bank_q[0] <= key[255:128];
      if (keylen == AES_256_BIT_KEY) bank_q[1] <= key[127:0];
    end else if (state_q == ST_GEN && int'(cnt_q) < NUM_KEYS) begin
      bank_q[cnt_q] <= next_key;
    end
  end

  assign round_key = (round_idx <= last_idx) ? bank_q[round_idx] : '0;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors, restart/reset cases and random keys
// against a word-oriented FIPS key-expansion model with an arithmetically derived sbox.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         init;
  logic         keylen;
  logic [255:0] key;
  logic [3:0]   round_idx;
  logic [127:0] round_key;
  logic         ready;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [16];

  localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .keylen    (keylen),
    .key       (key),
    .round_idx (round_idx),
    .round_key (round_key),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} << n;
    return d[15:8];
  endfunction

  // sbox = affine transform of the GF(2^8) multiplicative inverse
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion over 32-bit words; unused indices expected as zero
  task automatic model(input logic [255:0] k, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk = kl ? 8 : 4;
    int nw = kl ? 60 : 44;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      if (4*r + 3 < nw) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else              exp_rk[r] = '0;
  endtask

  task automatic rd(input logic [3:0] i, output logic [127:0] v);
    round_idx = i;
    #1;
    v = round_key;
  endtask

  task automatic check_all(input string tag);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      chk($sformatf("%s_idx%0d", tag, i), v, exp_rk[i]);
    end
  endtask

  task automatic check_idx(input string tag, input logic [3:0] i, input logic [127:0] exp);
    logic [127:0] v;
    rd(i, v);
    chk(tag, v, exp);
  endtask

  // Returns one time unit after the edge that sampled init; key/keylen then scrambled.
  task automatic start(input logic [255:0] k, input logic kl);
    @(negedge clk);
    key    = k;
    keylen = kl;
    init   = 1'b1;
    @(posedge clk);
    #1;
    init   = 1'b0;
    key    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    keylen = ~kl;
  endtask

  task automatic wait_ready(input string tag, input int lat);
    int cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!ready && cyc < 40);
    chk(tag, 128'(cyc), 128'(lat));
  endtask

  initial begin
    logic [255:0] rk;
    logic         rl;
    rst_n = 1'b0;
    init = 1'b0; keylen = 1'b0; key = '0; round_idx = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 128'(ready), 128'(0));
    for (int i = 0; i < 16; i += 5) check_idx($sformatf("rst_idx%0d", i), 4'(i), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 A.1
    start(KEY_A1, 1'b0);
    chk("a1_ready_low", 128'(ready), 128'(0));
    wait_ready("a1_latency", 10);
    check_idx("a1_idx1",  4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
    check_idx("a1_idx10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_idx("a1_idx11", 4'd11, 128'h0);
    model(KEY_A1, 1'b0);
    check_all("a1");

    // FIPS-197 C.1
    start(KEY_C1, 1'b0);
    wait_ready("c1_latency", 10);
    check_idx("c1_idx0",  4'd0,  128'h000102030405060708090a0b0c0d0e0f);
    check_idx("c1_idx10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // FIPS-197 A.3
    start(KEY_A3, 1'b1);
    wait_ready("a3_latency", 13);
    check_idx("a3_idx1",  4'd1,  128'h1f352c073b6108d72d9810a30914dff4);
    check_idx("a3_idx2",  4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde);
    check_idx("a3_idx14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
    check_idx("a3_idx15", 4'd15, 128'h0);
    model(KEY_A3, 1'b1);
    check_all("a3");

    // Restart after ready: AES-128 over a complete AES-256 bank
    start(KEY_A1, 1'b0);
    chk("rar_ready_drop", 128'(ready), 128'(0));
    wait_ready("rar_latency", 10);
    check_idx("rar_idx12", 4'd12, 128'h0);
    check_idx("rar_idx10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Restart mid-GEN, four cycles after the first init
    start(KEY_A1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    start(KEY_C1, 1'b0);
    wait_ready("rmg_latency", 10);
    check_idx("rmg_idx10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // init held for three edges: latency counts from the last sample
    @(negedge clk);
    key = KEY_A3; keylen = 1'b1; init = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    init = 1'b0; keylen = 1'b0; key = '0;
    wait_ready("hold_latency", 13);
    check_idx("hold_idx14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);

    // Reset during the 5th GEN cycle
    start(KEY_A1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmid_ready", 128'(ready), 128'(0));
    for (int i = 0; i < 16; i++) check_idx($sformatf("rmid_idx%0d", i), 4'(i), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start(KEY_A1, 1'b0);
    wait_ready("rpost_latency", 10);
    model(KEY_A1, 1'b0);
    check_all("rpost");

    // Random keys of both lengths
    for (int n = 0; n < 8; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rl = 1'($urandom_range(0, 1));
      start(rk, rl);
      wait_ready($sformatf("rnd%0d_latency", n), rl ? 13 : 10);
      model(rk, rl);
      check_all($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
